// File: rtl/six_tap_window.sv
// Six-pixel sliding window feeder for the six-tap half-pel filter.
// Pixels arrive one per accepted handshake, row by row. Taps a..f hold
// the six most recent pixels of the current row, with a the oldest.
// half_valid reproduces win_valid two cycles later so it lines up with
// the filter's registered output.
//
// state   | meaning
// --------+-----------------------------------------------------------
// FILL    | fewer than six pixels of the row accepted; no window yet
// STREAM  | window full; one window per accepted pixel
// ROW_END | single bubble after the last pixel; row_done, not ready
module six_tap_window #(
   parameter int ROW_LEN = 21,
   parameter int PIX_W   = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [PIX_W-1:0] pix_in,
   input  logic             pix_valid,
   output logic             pix_ready,
   input  logic             row_start,
   output logic [PIX_W-1:0] a,
   output logic [PIX_W-1:0] b,
   output logic [PIX_W-1:0] c,
   output logic [PIX_W-1:0] d,
   output logic [PIX_W-1:0] e,
   output logic [PIX_W-1:0] f,
   output logic             win_valid,
   output logic             half_valid,
   output logic             row_done
);

   localparam int CW = $clog2(ROW_LEN + 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(5);
   localparam logic [CW-1:0] CNT_LAST = CW'(ROW_LEN - 1);

   typedef enum logic [1:0] {
      FILL    = 2'd0,
      STREAM  = 2'd1,
      ROW_END = 2'd2
   } state_t;

   state_t           state, state_nx;
   logic [CW-1:0]    pix_cnt, pix_cnt_nx;
   logic             win_nx;
   logic             accept;
   logic [PIX_W-1:0] tap [6];
   logic [1:0]       half_pipe;

   assign accept = pix_valid & pix_ready;

   // State, pixel counter and the registered handshake/status outputs.
   // pix_ready and row_done are registered from the next state, so they
   // are low during reset and the ROW_END bubble is exactly one cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= FILL;
         pix_cnt   <= '0;
         pix_ready <= 1'b0;
         row_done  <= 1'b0;
         win_valid <= 1'b0;
      end else begin
         state     <= state_nx;
         pix_cnt   <= pix_cnt_nx;
         pix_ready <= (state_nx != ROW_END);
         row_done  <= (state_nx == ROW_END);
         win_valid <= win_nx;
      end
   end

   // Next-state, counter and window-valid decode.
   always_comb begin
      state_nx   = state;
      pix_cnt_nx = pix_cnt;
      win_nx     = 1'b0;
      case (state)
         FILL, STREAM: begin
            if (accept) begin
               if (row_start) begin
                  // Abort of any partial row: this pixel becomes index 0.
                  pix_cnt_nx = CW'(1);
                  state_nx   = FILL;
               end else begin
                  win_nx = (pix_cnt >= CNT_FULL);
                  if (pix_cnt == CNT_LAST) begin
                     pix_cnt_nx = '0;
                     state_nx   = ROW_END;
                  end else begin
                     pix_cnt_nx = pix_cnt + CW'(1);
                     if (state == FILL && pix_cnt == CNT_FULL)
                        state_nx = STREAM;
                  end
               end
            end
         end
         ROW_END: begin
            pix_cnt_nx = '0;
            state_nx   = FILL;
         end
         default: begin
            pix_cnt_nx = '0;
            state_nx   = FILL;
         end
      endcase
   end

   // Tap shift register: advances only on an accepted pixel.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 6; i++) tap[i] <= '0;
      end else if (accept) begin
         for (int i = 0; i < 5; i++) tap[i] <= tap[i+1];
         tap[5] <= pix_in;
      end
   end

   // Two-stage valid delay matching the filter latency; never stalls.
   always_ff @(posedge clk) begin
      if (!rst_n) half_pipe <= '0;
      else        half_pipe <= {half_pipe[0], win_valid};
   end

   assign half_valid = half_pipe[1];
   assign a = tap[0];
   assign b = tap[1];
   assign c = tap[2];
   assign d = tap[3];
   assign e = tap[4];
   assign f = tap[5];

endmodule

// File: tb/tb_six_tap_window.sv
// Scoreboard bench for six_tap_window. The driver feeds pixels and a
// row-based reference model pushes every expected window; a monitor pops
// and compares whenever the DUT raises win_valid.
module tb_six_tap_window;

   localparam int ROW_LEN = 21;
   localparam int PIX_W   = 8;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [PIX_W-1:0] pix_in;
   logic             pix_valid;
   logic             pix_ready;
   logic             row_start;
   logic [PIX_W-1:0] a, b, c, d, e, f;
   logic             win_valid, half_valid, row_done;

   six_tap_window #(.ROW_LEN(ROW_LEN), .PIX_W(PIX_W)) dut (
      .clk(clk), .rst_n(rst_n), .pix_in(pix_in), .pix_valid(pix_valid),
      .pix_ready(pix_ready), .row_start(row_start),
      .a(a), .b(b), .c(c), .d(d), .e(e), .f(f),
      .win_valid(win_valid), .half_valid(half_valid), .row_done(row_done)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model: the pixels of the current row, newest last.
   logic [PIX_W-1:0]     row_q [$];
   logic [6*PIX_W-1:0]   exp_win [$];
   int                   exp_rows = 0;
   int                   exp_wins = 0;
   int                   got_rows = 0;
   int                   got_wins = 0;
   int                   seg_wins = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
      end
   endtask

   task automatic model_accept(input logic [PIX_W-1:0] v, input logic rs);
      int n;
      if (rs) row_q.delete();
      row_q.push_back(v);
      n = row_q.size();
      if (n >= 6) begin
         exp_win.push_back({row_q[n-6], row_q[n-5], row_q[n-4],
                            row_q[n-3], row_q[n-2], row_q[n-1]});
         exp_wins++;
      end
      if (n == ROW_LEN) begin
         exp_rows++;
         row_q.delete();
      end
   endtask

   // Called at a falling edge; returns at the falling edge after acceptance.
   task automatic send(input logic [PIX_W-1:0] v, input logic rs);
      int guard = 0;
      pix_valid = 1'b1;
      pix_in    = v;
      row_start = rs;
      while (!pix_ready) begin
         @(negedge clk);
         guard++;
         if (guard > 10) begin
            check("accept_timeout", 64'd0, 64'd1);
            pix_valid = 1'b0;
            row_start = 1'b0;
            return;
         end
      end
      model_accept(v, rs);
      @(negedge clk);
      pix_valid = 1'b0;
      row_start = 1'b0;
   endtask

   task automatic idle(input int n);
      pix_valid = 1'b0;
      row_start = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      pix_valid = 1'b0;
      row_start = 1'b0;
      rst_n     = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      row_q.delete();
   endtask

   // Monitor: samples just after each rising edge.
   logic [1:0] hist = '0;
   logic       after_rst = 1'b0;
   always @(posedge clk) begin
      #1;
      if (!rst_n) begin
         check("rst_taps", {a, b, c, d, e, f}, 64'd0);
         check("rst_flags", {pix_ready, win_valid, half_valid, row_done}, 64'd0);
         hist      = '0;
         after_rst = 1'b1;
      end else begin
         if (win_valid) begin
            got_wins++;
            seg_wins++;
            if (exp_win.size() == 0) check("unexpected_window", 64'd1, 64'd0);
            else check("window", {a, b, c, d, e, f}, exp_win.pop_front());
         end
         check("half_valid", half_valid, hist[1]);
         hist = {hist[0], win_valid};
         if (row_done) begin
            got_rows++;
            check("ready_at_row_done", pix_ready, 1'b0);
         end else if (!after_rst) begin
            check("ready_outside_bubble", pix_ready, 1'b1);
         end
         after_rst = 1'b0;
      end
   end

   initial begin
      logic [PIX_W-1:0] v;
      rst_n     = 1'b0;
      pix_valid = 1'b0;
      pix_in    = '0;
      row_start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Row of 0..20 back to back, row_start on pixel 0.
      seg_wins = 0;
      for (int i = 0; i < ROW_LEN; i++) send(PIX_W'(i), i == 0);
      idle(4);
      check("row1_windows", seg_wins, 16);
      check("row1_done", got_rows, 1);

      // Same row with a gap every other cycle.
      seg_wins = 0;
      for (int i = 0; i < ROW_LEN; i++) begin
         send(PIX_W'(i), 1'b0);
         idle(1);
      end
      idle(4);
      check("row2_windows", seg_wins, 16);

      // Restart with pixel 10 = 0xAA, then finish the restarted row.
      seg_wins = 0;
      for (int i = 0; i < 10; i++) send(PIX_W'(i), 1'b0);
      send(8'hAA, 1'b1);
      for (int i = 1; i < ROW_LEN; i++) send(PIX_W'(8'h30 + i), 1'b0);
      idle(4);
      check("restart_windows", seg_wins, 5 + 16);

      // Reset after pixel 8, then a clean row.
      for (int i = 0; i < 9; i++) send(PIX_W'(8'h50 + i), 1'b0);
      do_reset();
      seg_wins = 0;
      for (int i = 0; i < ROW_LEN; i++) send(PIX_W'(8'h70 + i), 1'b0);
      idle(4);
      check("post_reset_windows", seg_wins, 16);

      // Two rows back to back with pix_valid held high.
      seg_wins = 0;
      for (int i = 0; i < 2 * ROW_LEN; i++) begin
         pix_valid = 1'b1;
         pix_in    = PIX_W'(8'hC0 + i);
         row_start = 1'b0;
         if (pix_ready) begin
            model_accept(pix_in, 1'b0);
            @(negedge clk);
         end else begin
            @(negedge clk);
            i--;
         end
      end
      idle(4);
      check("two_row_windows", seg_wins, 32);

      // Random rows: random data, gaps and occasional aborts.
      for (int r = 0; r < 30; r++) begin
         int len;
         len = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, ROW_LEN - 1)) : ROW_LEN;
         for (int i = 0; i < len; i++) begin
            v = PIX_W'($urandom);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            send(v, (i == 0) && ((len != ROW_LEN) || ($urandom_range(0, 1) == 1)));
         end
         if (len != ROW_LEN) begin
            send(PIX_W'($urandom), 1'b1);
            for (int i = 1; i < ROW_LEN; i++) send(PIX_W'($urandom), 1'b0);
         end
      end
      idle(6);

      check("leftover_windows", exp_win.size(), 0);
      check("window_count", got_wins, exp_wins);
      check("row_count", got_rows, exp_rows);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
